key_schedule_iter: RTL
======================

KEY_SCHEDULE_ITER -- requirements
Module: key_schedule_iter

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, AES key length; legal values 128, 192 and 256, any other value fails elaboration.
REQ-002 SHALL derive Nk = KEY_BITS/32, Nr = Nk+6 and NW = 4*(Nr+1) (44/52/60 words) internally.
REQ-003 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have start, input, 1, request expansion of key_in; accepted only when busy=0.
REQ-006 SHALL have key_in, input, KEY_BITS, cipher key, MSB = first byte of w0 (FIPS-197 order), sampled only in the accept cycle.
REQ-007 SHALL have busy, output, 1, high from the cycle after accept until the cycle done pulses, inclusive.
REQ-008 SHALL have rk_valid, output, 1, rk_out/rk_idx hold a round key.
REQ-009 SHALL have rk_ready, input, 1, consumer accepts the round key when rk_valid and rk_ready are both high.
REQ-010 SHALL have rk_idx, output, 4, round index 0..Nr of rk_out.
REQ-011 SHALL have rk_out, output, 128, round key {w[4i], w[4i+1], w[4i+2], w[4i+3]}, w[4i] in MSBs.
REQ-012 SHALL have done, output, 1, one-cycle pulse after round key Nr is accepted.

Function
REQ-013 SHALL use FSM states IDLE, GEN, DRAIN; IDLE->GEN on accepted start, GEN->DRAIN after word NW-1 is produced, DRAIN->IDLE on acceptance of round key Nr.
REQ-014 SHALL produce exactly one word w[j] per unstalled GEN cycle, j = 0..NW-1 in order, starting the cycle after accept.
REQ-015 SHALL take w[j] for j<Nk directly from the latched key.
REQ-016 SHALL compute w[j] = w[j-Nk] ^ SubWord(RotWord(w[j-1])) ^ {Rcon,24'h0} when j mod Nk = 0.
REQ-017 SHALL compute w[j] = w[j-Nk] ^ SubWord(w[j-1]) when Nk=8 and j mod 8 = 4.
REQ-018 SHALL compute w[j] = w[j-Nk] ^ w[j-1] for all other j>=Nk.
REQ-019 SHALL keep only the last Nk words in a sliding window register; no full NW-word storage.
REQ-020 SHALL reset Rcon to 8'h01 on accept and advance it by GF(2^8) xtime (poly 8'h1b) after each use: 01,02,04,08,10,20,40,80,1b,36.
REQ-021 SHALL implement SubWord with 4 combinational AES S-boxes.
REQ-022 SHALL collect words into a 4-word staging register; on the 4th word, transfer it to rk_out if rk_out is empty or being accepted that cycle, otherwise stall GEN.
REQ-023 SHALL, while stalled, hold the word counter, window, Rcon and staging register unchanged.
REQ-024 SHALL hold rk_out, rk_idx and rk_valid stable while rk_valid=1 and rk_ready=0.
REQ-025 SHALL, with rk_ready held high, first assert rk_valid for round key i 4i+5 cycles after the accept cycle.
REQ-026 SHALL, with rk_ready held high, give done = accept + 4*Nr+6 cycles (46/54/62).
REQ-027 SHALL ignore start while busy=1; start coincident with done's cycle is also ignored.
REQ-028 SHALL never deassert rk_valid without a handshake.

Reset
REQ-029 SHALL, on rst=1, go to IDLE and clear busy, rk_valid, done, rk_idx, rk_out, the window, the staging register and the counter to 0, with Rcon=8'h01.
REQ-030 SHALL let rst override all other inputs, including mid-expansion and stalled states, with no round key or done emitted afterwards until a new start.

Verification
REQ-031 SHALL test KEY_BITS=128 with key 2b7e151628aed2a6abf7158809cf4f3c and rk_ready=1 -> rk_idx1 = a0fafe1788542cb123a339392a6c7605; rk_idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6; done at accept+46.
REQ-032 SHALL test KEY_BITS=192 with key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> rk_idx12 = e98ba06f448c773c8ecc720401002202; 13 keys; done at accept+54.
REQ-033 SHALL test KEY_BITS=256 with key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> rk_idx0 = 603deb1015ca71be2b73aef0857d7781; rk_idx14 = fe4890d1e6188d0b046df344706c631e.
REQ-034 SHALL test random rk_ready backpressure (including 20-cycle low stretches) -> identical key sequence to REQ-031, outputs stable while stalled, no key lost or duplicated.
REQ-035 SHALL test start pulsed while busy with a different key_in -> ignored, output sequence unchanged.
REQ-036 SHALL test rst asserted at rk_idx 5 while stalled -> all outputs 0 next cycle; a new start then yields the full correct sequence from rk_idx 0.

Source files
------------

// File: rtl/key_schedule_iter_if.sv
// rtl/key_schedule_iter_if.sv - start/key request and round-key stream bundle for key_schedule_iter
interface key_schedule_iter_if #(
  parameter int KEY_BITS = 128
);
  logic                start;
  logic [KEY_BITS-1:0] key_in;
  logic                busy;
  logic                rk_valid;
  logic                rk_ready;
  logic [3:0]          rk_idx;
  logic [127:0]        rk_out;
  logic                done;

  modport master (
    output start, key_in, rk_ready,
    input  busy, rk_valid, rk_idx, rk_out, done
  );

  modport slave (
    input  start, key_in, rk_ready,
    output busy, rk_valid, rk_idx, rk_out, done
  );
endinterface

// File: rtl/key_schedule_iter.sv
// rtl/key_schedule_iter.sv - iterative AES key expansion, one word per cycle, round keys on a valid/ready stream
module key_schedule_iter #(
  parameter int KEY_BITS = 128
) (
  input logic         clk,
  input logic         rst,
  key_schedule_iter_if.slave ks
);
  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam int NW = 4 * (NR + 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
    $error("key_schedule_iter: KEY_BITS must be 128, 192 or 256");
  end

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  typedef enum logic [1:0] {IDLE, GEN, DRAIN} state_t;

  state_t              state, state_nx;
  logic [KEY_BITS-1:0] win;
  logic [31:0]         stage [4];
  logic [5:0]          wcnt;
  logic [2:0]          kcnt;
  logic [7:0]          rcon;
  logic                rk_valid_r;
  logic                done_r;
  logic [3:0]          rk_idx_r;
  logic [127:0]        rk_out_r;

  logic        busy, accept, hs, last4, slot_free, advance, xfer, first, last_word;
  logic [31:0] w_prev, w_old, sub_in, sub_out, w_new;

  assign busy      = (state != IDLE) || done_r;
  assign accept    = ks.start && !busy;
  assign hs        = rk_valid_r && ks.rk_ready;
  assign last4     = (wcnt[1:0] == 2'b11);
  assign slot_free = !rk_valid_r || ks.rk_ready;
  assign advance   = (state == GEN) && (!last4 || slot_free);
  assign xfer      = advance && last4;
  assign first     = (wcnt < 6'(NK));
  assign last_word = (wcnt == 6'(NW - 1));

  // Window holds w[j-NK] in the MSBs and w[j-1] in the LSBs; during the first
  // NK words it simply rotates the key, leaving it back in place for j = NK.
  always_comb begin
    w_prev  = win[31:0];
    w_old   = win[KEY_BITS-1 -: 32];
    sub_in  = (kcnt == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
    sub_out = {sbox(sub_in[31:24]), sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    w_new   = w_old ^ w_prev;
    if (first) begin
      w_new = w_old;
    end else if (kcnt == 3'd0) begin
      w_new = w_old ^ sub_out ^ {rcon, 24'h0};
    end else if (NK == 8 && kcnt == 3'd4) begin
      w_new = w_old ^ sub_out;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = GEN;
      GEN:     if (advance && last_word) state_nx = DRAIN;
      DRAIN:   if (hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      win        <= '0;
      for (int i = 0; i < 4; i++) stage[i] <= '0;
      wcnt       <= '0;
      kcnt       <= '0;
      rcon       <= 8'h01;
      rk_valid_r <= 1'b0;
      done_r     <= 1'b0;
      rk_idx_r   <= '0;
      rk_out_r   <= '0;
    end else begin
      state  <= state_nx;
      done_r <= (state == DRAIN) && hs;
      if (accept) begin
        win  <= ks.key_in;
        for (int i = 0; i < 4; i++) stage[i] <= '0;
        wcnt <= '0;
        kcnt <= '0;
        rcon <= 8'h01;
      end else if (advance) begin
        win               <= {win[KEY_BITS-33:0], w_new};
        stage[wcnt[1:0]]  <= w_new;
        wcnt              <= wcnt + 6'd1;
        kcnt              <= (kcnt == 3'(NK - 1)) ? 3'd0 : kcnt + 3'd1;
        if (!first && kcnt == 3'd0) rcon <= xtime(rcon);
      end
      if (xfer) begin
        rk_out_r   <= {stage[0], stage[1], stage[2], w_new};
        rk_idx_r   <= wcnt[5:2];
        rk_valid_r <= 1'b1;
      end else if (hs) begin
        rk_valid_r <= 1'b0;
      end
    end
  end

  assign ks.busy     = busy;
  assign ks.rk_valid = rk_valid_r;
  assign ks.rk_idx   = rk_idx_r;
  assign ks.rk_out   = rk_out_r;
  assign ks.done     = done_r;
endmodule
